gcd_host_driver: RTL

Synthesizable host-side driver for the EC2 microprocessor's operand/result protocol. It accepts an (X, Y) operand pair and presents each operand on `Input` with a timed `Enter` pulse. It then waits for `Halt`, captures the processor's `Output`, and checks it against an internal subtractive-GCD reference engine. It sits between a host (switches, UART shim or on-chip sequencer) and the processor, and keeps a running mismatch count for on-board self-test.

---
 rtl/gcd_host_driver.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/gcd_host_driver.sv
// Host-side operand/result driver for the EC2 processor.
// Sequences X/Y onto Input with timed Enter strobes, then checks Output against a GCD engine.
module gcd_host_driver #(
  parameter int GAP_CYCLES   = 5,
  parameter int ENTER_CYCLES = 3,
  parameter int TIMEOUT      = 1023
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [7:0] X_in,
  input  logic [7:0] Y_in,
  input  logic       Halt,
  input  logic [7:0] ProcOut,
  output logic       Enter,
  output logic [7:0] Input,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] Result,
  output logic       Match,
  output logic       Timeout,
  output logic       Reject,
  output logic [7:0] ErrCount
);

  localparam int CW = 16;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP1,
    S_ENT1,
    S_GAP2,
    S_ENT2,
    S_WAIT,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [TW-1:0] tcnt_inc;
  logic [7:0]    y_q, y_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    ry_q, ry_d;
  logic          armed_q, armed_d;
  logic [7:0]    input_q, input_d;
  logic [7:0]    result_q, result_d;
  logic          match_q, match_d;
  logic          timeout_q, timeout_d;
  logic          reject_q, reject_d;
  logic [7:0]    err_q, err_d;
  logic          ref_done;
  logic          ops_ok;
  logic          in_run;

  assign ref_done = (rx_q == ry_q);
  assign ops_ok   = (X_in != 8'd0) && (Y_in != 8'd0);
  assign tcnt_inc = tcnt_q + TW'(1);
  assign in_run   = (state_q == S_GAP1) || (state_q == S_ENT1) ||
                    (state_q == S_GAP2) || (state_q == S_ENT2) ||
                    (state_q == S_WAIT);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      cyc_q     <= '0;
      tcnt_q    <= '0;
      y_q       <= '0;
      rx_q      <= '0;
      ry_q      <= '0;
      armed_q   <= 1'b0;
      input_q   <= '0;
      result_q  <= '0;
      match_q   <= 1'b0;
      timeout_q <= 1'b0;
      reject_q  <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      tcnt_q    <= tcnt_d;
      y_q       <= y_d;
      rx_q      <= rx_d;
      ry_q      <= ry_d;
      armed_q   <= armed_d;
      input_q   <= input_d;
      result_q  <= result_d;
      match_q   <= match_d;
      timeout_q <= timeout_d;
      reject_q  <= reject_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    tcnt_d    = tcnt_q;
    y_d       = y_q;
    rx_d      = rx_q;
    ry_d      = ry_q;
    armed_d   = armed_q;
    input_d   = input_q;
    result_d  = result_q;
    match_d   = match_q;
    timeout_d = timeout_q;
    reject_d  = 1'b0;
    err_d     = err_q;

    // Subtractive GCD, one step per cycle while a run is active
    if (state_q != S_IDLE) begin
      unique case (1'b1)
        (rx_q > ry_q): rx_d = rx_q - ry_q;
        (ry_q > rx_q): ry_d = ry_q - rx_q;
        default: ;
      endcase
    end

    // A Halt left over from the last run is ignored until it drops
    if (in_run && !Halt) begin
      armed_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (ops_ok) begin
            input_d = X_in;
            y_d     = Y_in;
            rx_d    = X_in;
            ry_d    = Y_in;
            armed_d = 1'b0;
            cyc_d   = '0;
            state_d = S_GAP1;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      S_GAP1: begin
        if (cyc_q == CW'(GAP_CYCLES - 1)) begin
          cyc_d   = '0;
          state_d = S_ENT1;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_ENT1: begin
        if (cyc_q == CW'(ENTER_CYCLES - 1)) begin
          cyc_d   = '0;
          input_d = y_q;
          state_d = S_GAP2;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_GAP2: begin
        if (cyc_q == CW'(GAP_CYCLES - 1)) begin
          cyc_d   = '0;
          state_d = S_ENT2;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_ENT2: begin
        if (cyc_q == CW'(ENTER_CYCLES - 1)) begin
          cyc_d   = '0;
          tcnt_d  = '0;
          state_d = S_WAIT;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (armed_q && Halt && ref_done) begin
          result_d  = ProcOut;
          match_d   = (ProcOut == rx_q);
          timeout_d = 1'b0;
          state_d   = S_DONE;
        end else if (tcnt_inc == TW'(TIMEOUT)) begin
          result_d  = ProcOut;
          match_d   = 1'b0;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          tcnt_d = tcnt_inc;
        end
      end
      S_DONE: begin
        if (!match_q && (err_q != 8'hFF)) begin
          err_d = err_q + 8'd1;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign Enter    = (state_q == S_ENT1) || (state_q == S_ENT2);
  assign Input    = input_q;
  assign Busy     = in_run;
  assign Done     = (state_q == S_DONE);
  assign Result   = result_q;
  assign Match    = match_q;
  assign Timeout  = timeout_q;
  assign Reject   = reject_q;
  assign ErrCount = err_q;

endmodule
